// File: rtl/score_pkg.sv
// Shared constants and types for the score display scanner:
// segment codes, slot count, player-select codes and the snapshot layout.
package score_pkg;

  localparam int unsigned NUM_SLOTS = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Active-high {g,f,e,d,c,b,a} codes; element k is digit k.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [2:0] SEL_P1 = 3'b001;
  localparam logic [2:0] SEL_P2 = 3'b010;
  localparam logic [2:0] SEL_P3 = 3'b011;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    logic [2:0] chose;
  } snap_t;

  // True when the slot holds a digit of the player named by the select code.
  function automatic logic slot_selected(input logic [2:0] sel, input logic [2:0] slot);
    logic hit;
    hit = 1'b0;
    case (sel)
      SEL_P1:  hit = (slot[2:1] == 2'd0);
      SEL_P2:  hit = (slot[2:1] == 2'd1);
      SEL_P3:  hit = (slot[2:1] == 2'd2);
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-high seven-segment code, with optional
// blanking of a zero digit and a dash for non-BCD nibbles.
module bcd_to_seg
  import score_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_zero_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_zero_i && (digit_i == 4'd0)) begin
      seg_o = SEG_BLANK;
    end else if (digit_i <= 4'd9) begin
      seg_o = SEG_DIGITS[digit_i];
    end
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 6-digit display of three BCD player scores with input
// synchronisation, coherent snapshot, guard cycles and selected-player blink.
module score_display_scan
  import score_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  input  logic [2:0] chose,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic       frame_tick
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned FW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);
  localparam logic [2:0]    SLOT_LAST  = 3'(NUM_SLOTS - 1);

  snap_t in_bus;
  snap_t sync1_q, sync2_q, prev_q, snap_q, snap_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    slot_q, slot_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          blink_q, blink_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    dig_q, dig_d;
  logic          tick_q, tick_d;

  logic          slot_wrap, frame_wrap, blanked;
  logic [7:0]    score;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;

  assign in_bus = {a1, a2, a3, chose};

  bcd_to_seg u_bcd_to_seg (
    .digit_i      (nibble),
    .blank_zero_i (~slot_q[0]),
    .seg_o        (dec_seg)
  );

  always_comb begin
    // Only a value seen unchanged on two consecutive cycles is trusted.
    snap_d     = (sync2_q == prev_q) ? sync2_q : snap_q;
    slot_wrap  = (presc_q == PRESC_LAST);
    frame_wrap = slot_wrap && (slot_q == SLOT_LAST);
    presc_d    = slot_wrap ? '0 : presc_q + PW'(1);
    slot_d     = slot_q;
    if (slot_wrap) begin
      slot_d = frame_wrap ? 3'd0 : slot_q + 3'd1;
    end
    frame_d = frame_q;
    blink_d = blink_q;
    if (frame_wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FW'(1);
      end
    end
    tick_d = frame_wrap;
  end

  always_comb begin
    case (slot_q[2:1])
      2'd0:    score = snap_q.a1;
      2'd1:    score = snap_q.a2;
      default: score = snap_q.a3;
    endcase
    nibble  = slot_q[0] ? score[3:0] : score[7:4];
    blanked = blink_q && slot_selected(snap_q.chose, slot_q);
    seg_d   = blanked ? SEG_BLANK : dec_seg;
    // Count 0 of every slot is a guard cycle to suppress ghosting.
    dig_d   = (blanked || (presc_q == '0)) ? 6'h00 : (6'b000001 << slot_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      snap_q  <= '0;
      presc_q <= '0;
      slot_q  <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      seg_q   <= SEG_BLANK;
      dig_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= in_bus;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      snap_q  <= snap_d;
      presc_q <= presc_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
  assign dig_en     = ACTIVE_LOW ? ~dig_q : dig_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_score_display_scan.sv
// Scoreboard bench: stimulus queues expected frames, a monitor checks each
// 24-cycle frame window after frame_tick; plus reset and snapshot checks.
module tb_score_display_scan;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] a1, a2, a3;
  logic [2:0] chose;
  logic [6:0] seg, seg_al;
  logic [5:0] dig_en, dig_al;
  logic       tick, tick_al;

  always #5 clock = ~clock;

  score_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b0)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .chose      (chose),
    .seg        (seg),
    .dig_en     (dig_en),
    .frame_tick (tick)
  );

  score_display_scan #(.REFRESH_DIV(4), .BLINK_DIV(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clock      (clock),
    .reset_n    (reset_n),
    .a1         (a1),
    .a2         (a2),
    .a3         (a3),
    .chose      (chose),
    .seg        (seg_al),
    .dig_en     (dig_al),
    .frame_tick (tick_al)
  );

  typedef struct packed {
    logic [5:0][6:0] seg;
    logic [5:0][5:0] dig;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_busy = 1'b0;

  // Hand-computed slot vectors, slot 0 in the low element.
  localparam logic [5:0][6:0] V_DECODE  = {7'h6D, 7'h00, 7'h3F, 7'h06, 7'h4F, 7'h06};
  localparam logic [5:0][6:0] V_INVALID = {7'h3F, 7'h40, 7'h40, 7'h06, 7'h4F, 7'h06};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [5:0][6:0] segs, input logic [5:0] off);
    frame_t f;
    for (int k = 0; k < 6; k++) begin
      f.seg[k] = off[k] ? 7'h00 : segs[k];
      f.dig[k] = off[k] ? 6'h00 : 6'(1 << k);
    end
    exp_q.push_back(f);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!tick && n < 200);
    if (!tick) begin
      checks++;
      errors++;
      $display("FAIL frame_tick timeout: none within %0d cycles", n);
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((exp_q.size() > 0 || mon_busy) && i < 500) begin
      @(posedge clock);
      i++;
    end
    check("scoreboard drained", 32'(exp_q.size()) | 32'(mon_busy), 0);
    #1;
  endtask

  // Monitor: each window starts on a frame_tick and spans the next 24 cycles.
  initial begin
    frame_t cur;
    forever begin
      @(negedge clock);
      while (tick && exp_q.size() > 0) begin
        mon_busy = 1'b1;
        cur = exp_q.pop_front();
        for (int c = 0; c < 24; c++) begin
          @(negedge clock);
          check($sformatf("dig_en slot%0d cyc%0d", c / 4, c % 4), dig_en,
                (c % 4 == 0) ? 6'h00 : cur.dig[c / 4]);
          if (c % 4 != 0) begin
            check($sformatf("seg slot%0d cyc%0d", c / 4, c % 4), seg, cur.seg[c / 4]);
          end
          check($sformatf("frame_tick cyc%0d", c), tick, (c == 23));
        end
      end
      mon_busy = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a1 = 8'h13; a2 = 8'h10; a3 = 8'h05; chose = 3'b010;
    repeat (3) @(negedge clock);
    check("reset seg", seg, 7'h00);
    check("reset dig_en", dig_en, 6'h00);
    check("reset seg active-low", seg_al, 7'h7F);
    check("reset dig_en active-low", dig_al, 6'h3F);
    check("reset frame_tick", tick, 1'b0);
    reset_n = 1'b1;
    wait_tick(n);
    check("first tick latency", n, 24);

    // Mid-slot reset: slot 1 is lit, then reset must blank at once.
    repeat (6) @(posedge clock);
    #1;
    check("active-low slot1 dig_en", dig_al, 6'h3D);
    check("active-low slot1 seg", seg_al, 7'h30);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset seg active-low", seg_al, 7'h7F);
    check("async reset dig_en active-low", dig_al, 6'h3F);
    check("async reset seg", seg, 7'h00);
    check("async reset dig_en", dig_en, 6'h00);
    check("async reset frame_tick", tick_al, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_tick(n);
    check("tick latency after reset", n, 24);

    // Blink of player 2: frames 2..5 after reset.
    push_frame(V_DECODE, 6'b000000);
    push_frame(V_DECODE, 6'b001100);
    push_frame(V_DECODE, 6'b001100);
    push_frame(V_DECODE, 6'b000000);
    drain();

    chose = 3'b000;
    wait_tick(n);
    wait_tick(n);
    push_frame(V_DECODE, 6'b000000);
    push_frame(V_DECODE, 6'b000000);
    drain();

    chose = 3'b111;
    wait_tick(n);
    wait_tick(n);
    for (int i = 0; i < 4; i++) push_frame(V_DECODE, 6'b000000);
    drain();

    chose = 3'b000; a2 = 8'h1A; a3 = 8'hA0;
    wait_tick(n);
    wait_tick(n);
    push_frame(V_INVALID, 6'b000000);
    push_frame(V_INVALID, 6'b000000);
    drain();

    // Snapshot coherence and 4-cycle capture latency.
    @(negedge clock);
    a1 = 8'h09;
    repeat (6) @(posedge clock);
    #1;
    check("snapshot a1 settled", dut.snap_q.a1, 8'h09);
    @(negedge clock);
    a1 = 8'h10;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("snapshot a1 edge%0d", i), dut.snap_q.a1, (i < 4) ? 8'h09 : 8'h10);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      a1 = i[0] ? 8'h10 : 8'h09;
      @(posedge clock);
      #1;
      check($sformatf("snapshot a1 toggling %0d", i), dut.snap_q.a1, 8'h10);
    end
    check("snapshot a2 held", dut.snap_q.a2, 8'h1A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
